test_structure_sequencer: RTL and testbench
===========================================

Name: test_structure_sequencer

Overview:
- Sequences the test-structure array through a full characterisation scan.
- For each enabled structure: selects it, steps through every orientation, waits a programmable settle time, issues a measurement request, and records per-structure pass/fail/timeout status.
- Sits between the control register interface, which supplies start/abort/mask/settle, and the test-structure measurement datapath (req/ack).

Parameters:
- NUM_STRUCT, 8, number of test structures; index width IDX_W = $clog2(NUM_STRUCT).
- ORIENT_W, 2, orientation code width; orientations visited 0..2^ORIENT_W-1.
- SETTLE_W, 8, width of settle-cycle count.
- TIMEOUT_CYCLES, 16, maximum cycles meas_req may stay high without meas_ack.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset, asynchronous, active-high.
- start  in  1  begin scan; honoured only in IDLE.
- abort  in  1  terminate scan; return to IDLE.
- mask  in  NUM_STRUCT  structure enable bits; latched at start.
- settle_cycles  in  SETTLE_W  settle wait per orientation; latched at start.
- meas_ack  in  1  measurement complete; valid only while meas_req=1.
- meas_pass  in  1  measurement result; sampled with meas_ack.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on scan completion.
- sel  out  IDX_W  selected structure index.
- orient  out  ORIENT_W  current orientation code.
- enable  out  1  selected structure powered/connected.
- meas_req  out  1  measurement request.
- pass_vec  out  NUM_STRUCT  structure passed all orientations.
- fail_vec  out  NUM_STRUCT  structure failed an orientation.
- tmo_vec  out  NUM_STRUCT  structure measurement timed out.

Behaviour:
Reset: all outputs 0, state IDLE, internal counters 0.

State machine:
- IDLE
  - start=1 and abort=0: latch mask and settle_cycles; clear pass/fail/tmo vectors; set sel=0, orient=0; go to SCAN.
  - Otherwise stay in IDLE.
- SCAN
  - mask[sel]=0: skip the structure (one cycle). If sel=NUM_STRUCT-1 go to DONE, else sel+1 and stay in SCAN.
  - mask[sel]=1: set enable=1, load settle counter with settle_cycles, go to SETTLE.
- SETTLE
  - Lasts settle_cycles+1 cycles; counter decrements each cycle.
  - At counter=0 go to REQ.
- REQ
  - meas_req=1 throughout; timeout counter increments each cycle.
  - On meas_ack=1:
    - meas_pass=0: set fail_vec[sel], go to NEXT. Remaining orientations are skipped.
    - meas_pass=1 and orient<max: orient+1, reload settle counter, go to SETTLE.
    - meas_pass=1 and orient=max: set pass_vec[sel], go to NEXT.
  - If the timeout counter reaches TIMEOUT_CYCLES with no ack: set tmo_vec[sel], go to NEXT.
  - Ack on the same cycle as timeout: ack wins.
- NEXT
  - enable=0, orient=0.
  - If sel=NUM_STRUCT-1 go to DONE, else sel+1 and go to SCAN.
- DONE
  - done=1 for one cycle, then IDLE.
  - sel and orient hold last values until the next start.

Timing and handshake rules:
- meas_req is registered; it drops the cycle after ack is sampled.
- Ack while meas_req=0 is ignored.
- enable stays high across the orientations of one structure.
- Exactly one of pass/fail/tmo is set per unmasked structure; masked structures leave all three 0.

Abort and start conflicts:
- abort=1 in any non-IDLE state: next cycle state=IDLE; meas_req, enable and busy go to 0; status vectors retain partial results; no done pulse.
- abort and start both high in IDLE: stay in IDLE.
- start while busy is ignored; mask/settle changes during a scan have no effect.

Boundary cases:
- mask all zero: NUM_STRUCT SCAN cycles, then DONE; all vectors 0.
- RST mid-scan: immediately returns to reset values, including the vectors.

Test Plan:
- NUM_STRUCT=4, ORIENT_W=1, settle=2, mask=4'b1111, ack 1 cycle after req with pass=1 → 8 requests (sel 0..3 × orient 0,1); ≥3 cycles between enable rise and first req; pass_vec=4'b1111; single done pulse; busy low the cycle after done.
- mask=4'b0101, all pass → only sel 0 and 2 requested; pass_vec=4'b0101; fail_vec=tmo_vec=0.
- Structure 1 returns pass=0 on orient 0 → orient 1 not requested for sel 1; fail_vec=4'b0010; pass_vec=4'b1101.
- Never ack on sel 2 → meas_req high exactly 16 cycles; tmo_vec=4'b0100; scan continues to sel 3 and completes.
- Ack on the 16th req cycle → counted as a result, tmo_vec bit clear. Ack while req=0 → ignored.
- abort asserted during SETTLE of sel 1 → IDLE next cycle, enable=0, no done pulse, pass_vec[0] retained. start while busy → no restart.

Source files
------------

// File: rtl/test_structure_sequencer.sv
// Test-structure characterisation sequencer.
// Walks every enabled structure through all orientation codes. For each one it
// waits a settle time, requests a measurement, and records pass, fail or
// timeout status per structure. Abort returns to IDLE and keeps partial results.
module test_structure_sequencer #(
    parameter int NUM_STRUCT     = 8,
    parameter int ORIENT_W       = 2,
    parameter int SETTLE_W       = 8,
    parameter int TIMEOUT_CYCLES = 16,
    localparam int IDX_W         = $clog2(NUM_STRUCT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_STRUCT-1:0] mask,
    input  logic [SETTLE_W-1:0]   settle_cycles,
    input  logic                  meas_ack,
    input  logic                  meas_pass,
    output logic                  busy,
    output logic                  done,
    output logic [IDX_W-1:0]      sel,
    output logic [ORIENT_W-1:0]   orient,
    output logic                  enable,
    output logic                  meas_req,
    output logic [NUM_STRUCT-1:0] pass_vec,
    output logic [NUM_STRUCT-1:0] fail_vec,
    output logic [NUM_STRUCT-1:0] tmo_vec
);

    // Timeout counter only needs to reach TIMEOUT_CYCLES-1; the last REQ cycle
    // is the one where the counter holds that value.
    localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_SEL = IDX_W'(NUM_STRUCT - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_SETTLE,
        ST_REQ,
        ST_NEXT,
        ST_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      sel_q, sel_d;
    logic [ORIENT_W-1:0]   orient_q, orient_d;
    logic                  enable_q, enable_d;
    logic                  meas_req_q, meas_req_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [NUM_STRUCT-1:0] mask_q, mask_d;
    logic [SETTLE_W-1:0]   settle_q, settle_d;
    logic [SETTLE_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic [NUM_STRUCT-1:0] pass_q, pass_d;
    logic [NUM_STRUCT-1:0] fail_q, fail_d;
    logic [NUM_STRUCT-1:0] tmo_q, tmo_d;

    logic sel_is_last;
    logic orient_is_max;

    assign sel_is_last   = (sel_q == LAST_SEL);
    assign orient_is_max = &orient_q;

    // Next-state, counter and status logic; abort overrides all in-scan activity.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        orient_d     = orient_q;
        enable_d     = enable_q;
        mask_d       = mask_q;
        settle_d     = settle_q;
        settle_cnt_d = settle_cnt_q;
        tmo_cnt_d    = '0;
        pass_d       = pass_q;
        fail_d       = fail_q;
        tmo_d        = tmo_q;

        if (abort && (state_q != ST_IDLE)) begin
            state_d  = ST_IDLE;
            enable_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        mask_d   = mask;
                        settle_d = settle_cycles;
                        pass_d   = '0;
                        fail_d   = '0;
                        tmo_d    = '0;
                        sel_d    = '0;
                        orient_d = '0;
                        enable_d = 1'b0;
                        state_d  = ST_SCAN;
                    end
                end

                ST_SCAN: begin
                    if (mask_q[sel_q]) begin
                        enable_d     = 1'b1;
                        settle_cnt_d = settle_q;
                        state_d      = ST_SETTLE;
                    end else if (sel_is_last) begin
                        state_d = ST_DONE;
                    end else begin
                        sel_d = sel_q + IDX_W'(1);
                    end
                end

                ST_SETTLE: begin
                    if (settle_cnt_q == '0) begin
                        state_d = ST_REQ;
                    end else begin
                        settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
                    end
                end

                ST_REQ: begin
                    if (meas_ack) begin
                        if (!meas_pass) begin
                            fail_d[sel_q] = 1'b1;
                            state_d       = ST_NEXT;
                        end else if (orient_is_max) begin
                            pass_d[sel_q] = 1'b1;
                            state_d       = ST_NEXT;
                        end else begin
                            orient_d     = orient_q + ORIENT_W'(1);
                            settle_cnt_d = settle_q;
                            state_d      = ST_SETTLE;
                        end
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        tmo_d[sel_q] = 1'b1;
                        state_d      = ST_NEXT;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    end
                end

                ST_NEXT: begin
                    enable_d = 1'b0;
                    orient_d = '0;
                    if (sel_is_last) begin
                        state_d = ST_DONE;
                    end else begin
                        sel_d   = sel_q + IDX_W'(1);
                        state_d = ST_SCAN;
                    end
                end

                ST_DONE: begin
                    state_d = ST_IDLE;
                end

                default: begin
                    state_d  = ST_IDLE;
                    enable_d = 1'b0;
                end
            endcase
        end

        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
        meas_req_d = (state_d == ST_REQ);
    end

    // State and output registers; reset clears everything including status vectors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            orient_q     <= '0;
            enable_q     <= 1'b0;
            meas_req_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            mask_q       <= '0;
            settle_q     <= '0;
            settle_cnt_q <= '0;
            tmo_cnt_q    <= '0;
            pass_q       <= '0;
            fail_q       <= '0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            orient_q     <= orient_d;
            enable_q     <= enable_d;
            meas_req_q   <= meas_req_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            mask_q       <= mask_d;
            settle_q     <= settle_d;
            settle_cnt_q <= settle_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
            tmo_q        <= tmo_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sel      = sel_q;
    assign orient   = orient_q;
    assign enable   = enable_q;
    assign meas_req = meas_req_q;
    assign pass_vec = pass_q;
    assign fail_vec = fail_q;
    assign tmo_vec  = tmo_q;

endmodule

// File: tb/tb_test_structure_sequencer.sv
// Bench for test_structure_sequencer with four structures and two orientations.
// A responder models the measurement datapath. A monitor gathers per-scan
// statistics, which are compared against hand-computed expectations.
module tb_test_structure_sequencer;

    localparam int NS  = 4;
    localparam int OW  = 1;
    localparam int SW  = 8;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [NS-1:0] mask;
    logic [SW-1:0] settle_cycles;
    logic          meas_ack;
    logic          meas_pass;
    logic          busy;
    logic          done;
    logic [1:0]    sel;
    logic [OW-1:0] orient;
    logic          enable;
    logic          meas_req;
    logic [NS-1:0] pass_vec;
    logic [NS-1:0] fail_vec;
    logic [NS-1:0] tmo_vec;

    typedef struct {
        string      name;
        logic [3:0] mask;
        int         settle;
        int         ack_at;
        int         fail_sel;
        int         noack_sel;
        bit         spurious;
        logic [3:0] exp_pass;
        logic [3:0] exp_fail;
        logic [3:0] exp_tmo;
        logic [7:0] exp_reqmap;
        int         exp_busy;
        int         exp_maxrun;
        int         exp_gap;
    } vec_t;

    vec_t vecs[9];

    int checks = 0;
    int errors = 0;

    // Responder configuration, written only by the main test process.
    int cfg_ack_at    = 2;
    int cfg_fail_sel  = -1;
    int cfg_noack_sel = -1;
    bit cfg_spurious  = 1'b0;

    // Monitor statistics, written only by the monitor process.
    int         clear_req = 0;
    int         clear_ack = 0;
    logic [7:0] reqmap    = '0;
    int         busy_cnt  = 0;
    int         done_cnt  = 0;
    int         maxrun    = 0;
    int         first_gap = 0;
    int         busy_after_done = 0;

    test_structure_sequencer #(
        .NUM_STRUCT    (NS),
        .ORIENT_W      (OW),
        .SETTLE_W      (SW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .mask         (mask),
        .settle_cycles(settle_cycles),
        .meas_ack     (meas_ack),
        .meas_pass    (meas_pass),
        .busy         (busy),
        .done         (done),
        .sel          (sel),
        .orient       (orient),
        .enable       (enable),
        .meas_req     (meas_req),
        .pass_vec     (pass_vec),
        .fail_vec     (fail_vec),
        .tmo_vec      (tmo_vec)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Measurement datapath model: acks on the configured request cycle.
    initial begin
        int age;
        age       = 0;
        meas_ack  = 1'b0;
        meas_pass = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (meas_req) begin
                age++;
                if (age == cfg_ack_at && int'(sel) != cfg_noack_sel) begin
                    meas_ack  = 1'b1;
                    meas_pass = (int'(sel) != cfg_fail_sel);
                end else begin
                    meas_ack  = 1'b0;
                    meas_pass = 1'b0;
                end
            end else begin
                age       = 0;
                meas_ack  = cfg_spurious;
                meas_pass = 1'b0;
            end
        end
    end

    // Per-scan monitor: request map, busy length, done pulses, request run lengths.
    initial begin
        int   cyc;
        int   run;
        int   en_cyc;
        bit   en_seen;
        logic prev_req;
        logic prev_en;
        logic prev_done;
        cyc = 0; run = 0; en_cyc = 0; en_seen = 0;
        prev_req = 0; prev_en = 0; prev_done = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (clear_req != clear_ack) begin
                reqmap          = '0;
                busy_cnt        = 0;
                done_cnt        = 0;
                maxrun          = 0;
                first_gap       = 0;
                busy_after_done = 0;
                run             = 0;
                en_seen         = 0;
                prev_req        = 0;
                prev_en         = 0;
                prev_done       = 0;
                clear_ack       = clear_req;
            end
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (prev_done && busy) busy_after_done++;
            if (enable && !prev_en) begin
                en_cyc  = cyc;
                en_seen = 1;
            end
            if (meas_req && !prev_req) begin
                reqmap[{sel, orient}] = 1'b1;
                if (first_gap == 0 && en_seen) first_gap = cyc - en_cyc;
            end
            if (meas_req) begin
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
            prev_req  = meas_req;
            prev_en   = enable;
            prev_done = done;
        end
    end

    // Hard stop in case the flow itself stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired before summary");
        $fatal(1, "[TB] watchdog");
    end

    function automatic vec_t mkVec(string name, logic [3:0] m, int settle, int ack_at,
                                   int fail_sel, int noack_sel, bit spurious,
                                   logic [3:0] ep, logic [3:0] ef, logic [3:0] et,
                                   logic [7:0] erm, int eb, int emr, int eg);
        vec_t v;
        v.name = name; v.mask = m; v.settle = settle; v.ack_at = ack_at;
        v.fail_sel = fail_sel; v.noack_sel = noack_sel; v.spurious = spurious;
        v.exp_pass = ep; v.exp_fail = ef; v.exp_tmo = et; v.exp_reqmap = erm;
        v.exp_busy = eb; v.exp_maxrun = emr; v.exp_gap = eg;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Configure the responder, reset the monitor and pulse start for one cycle.
    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        cfg_ack_at    = v.ack_at;
        cfg_fail_sel  = v.fail_sel;
        cfg_noack_sel = v.noack_sel;
        cfg_spurious  = v.spurious;
        mask          = v.mask;
        settle_cycles = SW'(v.settle);
        clear_req     = clear_req + 1;
        start         = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input string name, input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        checkOutput({name, ".done_seen"}, 32'(seen), 32'd1);
        @(negedge clk);
        #1;
    endtask

    task automatic checkRow(input vec_t v);
        checkOutput({v.name, ".pass_vec"}, 32'(pass_vec), 32'(v.exp_pass));
        checkOutput({v.name, ".fail_vec"}, 32'(fail_vec), 32'(v.exp_fail));
        checkOutput({v.name, ".tmo_vec"}, 32'(tmo_vec), 32'(v.exp_tmo));
        checkOutput({v.name, ".reqmap"}, 32'(reqmap), 32'(v.exp_reqmap));
        checkOutput({v.name, ".busy_cycles"}, 32'(busy_cnt), 32'(v.exp_busy));
        checkOutput({v.name, ".max_req_run"}, 32'(maxrun), 32'(v.exp_maxrun));
        checkOutput({v.name, ".enable_to_req"}, 32'(first_gap), 32'(v.exp_gap));
        checkOutput({v.name, ".done_pulses"}, 32'(done_cnt), 32'd1);
        checkOutput({v.name, ".busy_after_done"}, 32'(busy_after_done), 32'd0);
        checkOutput({v.name, ".sel_hold"}, 32'(sel), 32'(NS - 1));
        checkOutput({v.name, ".idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        vec_t v;
        bit   found;

        vecs[0] = mkVec("all_pass",      4'b1111, 2,  2, -1, -1, 0, 4'b1111, 4'b0000, 4'b0000, 8'hFF, 49,  2, 3);
        vecs[1] = mkVec("mask_0101",     4'b0101, 2,  2, -1, -1, 0, 4'b0101, 4'b0000, 4'b0000, 8'h33, 27,  2, 3);
        vecs[2] = mkVec("fail_sel1",     4'b1111, 2,  2,  1, -1, 0, 4'b1101, 4'b0010, 4'b0000, 8'hF7, 44,  2, 3);
        vecs[3] = mkVec("tmo_sel2",      4'b1111, 2,  2, -1,  2, 0, 4'b1011, 4'b0000, 4'b0100, 8'hDF, 58, 16, 3);
        vecs[4] = mkVec("mask_zero",     4'b0000, 2,  2, -1, -1, 0, 4'b0000, 4'b0000, 4'b0000, 8'h00,  5,  0, 0);
        vecs[5] = mkVec("settle0_fail3", 4'b1010, 0,  2,  3, -1, 0, 4'b0010, 4'b1000, 4'b0000, 8'h4C, 16,  2, 1);
        vecs[6] = mkVec("ack_on_16th",   4'b0001, 2, 16, -1, -1, 0, 4'b0001, 4'b0000, 4'b0000, 8'h03, 44, 16, 3);
        vecs[7] = mkVec("no_ack_by_16",  4'b0001, 2, 17, -1, -1, 0, 4'b0000, 4'b0000, 4'b0001, 8'h01, 25, 16, 3);
        vecs[8] = mkVec("spurious_ack",  4'b1111, 2,  2, -1, -1, 1, 4'b1111, 4'b0000, 4'b0000, 8'hFF, 49,  2, 3);

        rst           = 1'b1;
        start         = 1'b0;
        abort         = 1'b0;
        mask          = '0;
        settle_cycles = '0;

        repeat (2) @(negedge clk);
        checkOutput("reset_outputs",
                    32'({busy, done, sel, orient, enable, meas_req, pass_vec, fail_vec, tmo_vec}), 32'd0);
        rst = 1'b0;

        $display("[TB] running %0d table vectors", 9);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
            waitDone(vecs[i].name, 2000);
            checkRow(vecs[i]);
        end

        // Start pulse mid-scan with a different mask must be ignored.
        v = mkVec("start_while_busy", 4'b0001, 2, 2, -1, -1, 0, 4'b0001, 4'b0000, 4'b0000, 8'h03, 16, 2, 3);
        applyStimulus(v);
        repeat (5) @(posedge clk);
        #1;
        start         = 1'b1;
        mask          = 4'b1111;
        settle_cycles = '0;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(v.name, 2000);
        checkRow(v);

        // Abort during SETTLE of structure 1.
        v = mkVec("abort", 4'b1111, 2, 2, -1, -1, 0, 4'b0, 4'b0, 4'b0, 8'h0, 0, 0, 0);
        applyStimulus(v);
        found = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sel == 2'd1 && enable && !meas_req) begin
                found = 1;
                break;
            end
        end
        checkOutput("abort.reach_sel1_settle", 32'(found), 32'd1);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checkOutput("abort.busy", 32'(busy), 32'd0);
        checkOutput("abort.enable", 32'(enable), 32'd0);
        checkOutput("abort.meas_req", 32'(meas_req), 32'd0);
        checkOutput("abort.pass_vec_kept", 32'(pass_vec), 32'h1);
        checkOutput("abort.fail_tmo", 32'({fail_vec, tmo_vec}), 32'd0);
        repeat (6) @(negedge clk);
        #1;
        checkOutput("abort.no_done", 32'(done_cnt), 32'd0);
        checkOutput("abort.stays_idle", 32'(busy), 32'd0);

        // Start and abort together in IDLE: no scan, results untouched.
        @(posedge clk);
        #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        checkOutput("start_abort_idle.busy", 32'(busy), 32'd0);
        checkOutput("start_abort_idle.pass_vec", 32'(pass_vec), 32'h1);

        // Asynchronous reset mid-scan clears everything without a clock edge.
        v = mkVec("reset_mid_scan", 4'b1111, 2, 2, -1, -1, 0, 4'b0, 4'b0, 4'b0, 8'h0, 0, 0, 0);
        applyStimulus(v);
        found = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (pass_vec[0]) begin
                found = 1;
                break;
            end
        end
        checkOutput("reset_mid_scan.reached", 32'(found), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("reset_mid_scan.outputs",
                    32'({busy, done, sel, orient, enable, meas_req, pass_vec, fail_vec, tmo_vec}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
